// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the system PLL from the 50 MHz reference clock. For each attempt
// it pulses the PLL reset, waits for lock with a timeout, and then requires
// lock to hold for a qualification window before declaring the clocks usable
// and releasing downstream reset. In RUN it watches lock continuously: a lock
// loss is counted and the PLL is re-sequenced automatically. After too many
// failed attempts it parks in FAULT with the PLL held in reset until a relock
// request or reset arrives.
//
// Ports
//   refclk       in   1  reference clock, sole clock of the block
//   rst          in   1  synchronous active-high reset
//   pll_locked   in   1  raw PLL lock indication, asynchronous to refclk
//   relock_req   in   1  single-cycle request to re-sequence (RUN/FAULT only)
//   pll_rst      out  1  reset to PLL, active high
//   sys_rst_req  out  1  downstream reset request, active high
//   ready        out  1  PLL locked and qualified
//   fault        out  1  retries exhausted, PLL held in reset
//   retry_cnt    out  8  failed attempts in the current sequence (saturating)
//   loss_cnt     out  8  lock losses seen in RUN since reset (saturating)
//   state_o      out  3  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 100,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_req,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts: the shared counter runs 0..N-1 in each timed state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    // Event counters hold at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic           lk_meta_r;
    logic           lk_r;
    state_t         state_r;
    state_t         state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]     retry_cnt_r;
    logic [7:0]     retry_nxt_s;
    logic [7:0]     loss_cnt_r;
    logic [7:0]     loss_nxt_s;
    logic           pll_rst_r;
    logic           sys_rst_req_r;
    logic           ready_r;
    logic           fault_r;

    // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= pll_locked;
            lk_r      <= lk_meta_r;
        end
    end

    // Next-state, cycle counter and event counter logic.
    always_comb begin
        state_nxt_s = ST_RESET_PLL;
        cnt_nxt_s   = CNT_ZERO;
        retry_nxt_s = retry_cnt_r;
        loss_nxt_s  = loss_cnt_r;
        case (state_r)
            ST_RESET_PLL: begin
                if (cnt_r == RST_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_RESET_PLL;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked before the timeout so a lock arriving on
                // the last wait cycle still counts as a success.
                if (lk_r) begin
                    state_nxt_s = ST_STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    if (retry_cnt_r < RETRY_LIMIT) begin
                        state_nxt_s = ST_RESET_PLL;
                        retry_nxt_s = sat_inc8(retry_cnt_r);
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // A glitch sends us back to wait with a fresh timeout but
                // does not count as a failed attempt.
                if (!lk_r) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = ST_RUN;
                    retry_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_STABLE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                // Lock loss takes priority over a simultaneous relock request.
                if (!lk_r) begin
                    state_nxt_s = ST_RESET_PLL;
                    loss_nxt_s  = sat_inc8(loss_cnt_r);
                end else if (relock_req) begin
                    state_nxt_s = ST_RESET_PLL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    state_nxt_s = ST_RESET_PLL;
                    retry_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_RESET_PLL;
            end
        endcase
    end

    // State, shared cycle counter and event counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r     <= ST_RESET_PLL;
            cnt_r       <= CNT_ZERO;
            retry_cnt_r <= 8'd0;
            loss_cnt_r  <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            retry_cnt_r <= retry_nxt_s;
            loss_cnt_r  <= loss_nxt_s;
        end
    end

    // Control outputs decoded from the next state so they switch with it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst_r     <= 1'b1;
            sys_rst_req_r <= 1'b1;
            ready_r       <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            pll_rst_r     <= (state_nxt_s == ST_RESET_PLL) || (state_nxt_s == ST_FAULT);
            sys_rst_req_r <= (state_nxt_s != ST_RUN);
            ready_r       <= (state_nxt_s == ST_RUN);
            fault_r       <= (state_nxt_s == ST_FAULT);
        end
    end

    assign pll_rst     = pll_rst_r;
    assign sys_rst_req = sys_rst_req_r;
    assign ready       = ready_r;
    assign fault       = fault_r;
    assign retry_cnt   = retry_cnt_r;
    assign loss_cnt    = loss_cnt_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer with short timing parameters
// (pulse 4, timeout 20, stable 8, two retries). Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, so every expected value
// below is the state after a known number of rising edges.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_req;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst_req (sys_rst_req),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt),
        .state_o     (state_o)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic prst,
                              input logic srr, input logic rdy, input logic flt,
                              input logic [7:0] rc, input logic [7:0] lc);
        check({tag, ".state"},       32'(state_o),     32'(st));
        check({tag, ".pll_rst"},     32'(pll_rst),     32'(prst));
        check({tag, ".sys_rst_req"}, 32'(sys_rst_req), 32'(srr));
        check({tag, ".ready"},       32'(ready),       32'(rdy));
        check({tag, ".fault"},       32'(fault),       32'(flt));
        check({tag, ".retry_cnt"},   32'(retry_cnt),   32'(rc));
        check({tag, ".loss_cnt"},    32'(loss_cnt),    32'(lc));
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (state_o !== st && n < max_cyc) begin
            tick(1);
            n++;
        end
        check(tag, 32'(state_o), 32'(st));
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(1);
        check_outs("reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        // Clean lock: 4-cycle PLL reset, then lock qualified after 2+8 cycles.
        rst = 1'b0;
        tick(3);
        check_outs("pulse_end", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        check_outs("wait_entry", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        pll_locked = 1'b1;
        tick(10);
        check_outs("stable_last", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        check_outs("run_entry", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

        // Relock request in RUN: re-sequence without counting a loss.
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("relock_run", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        pll_locked = 1'b0;
        tick(4);
        check("relock_wait", 32'(state_o), 32'(3'd1));
        // Relock request while waiting for lock is ignored.
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("relock_in_wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        // Never locks: timeouts retry twice, then FAULT.
        tick(18);
        check_outs("timeout1_pre", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        check_outs("timeout1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        tick(3);
        check("pulse2_end", 32'(pll_rst), 32'(1'b1));
        tick(1);
        check("wait2_entry", 32'(state_o), 32'(3'd1));
        tick(19);
        check("timeout2_pre", 32'(state_o), 32'(3'd1));
        tick(1);
        check_outs("timeout2", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
        tick(4);
        check("wait3_entry", 32'(state_o), 32'(3'd1));
        tick(19);
        check("timeout3_pre", 32'(state_o), 32'(3'd1));
        tick(1);
        check_outs("fault_entry", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
        tick(5);
        check_outs("fault_hold", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("fault_exit", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

        // One timeout to make retry_cnt nonzero, then a glitch in STABLE.
        tick(4);
        check("g_wait_entry", 32'(state_o), 32'(3'd1));
        tick(20);
        check_outs("g_timeout", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        pll_locked = 1'b1;
        tick(4);
        check("g_wait2", 32'(state_o), 32'(3'd1));
        tick(1);
        check("g_stable", 32'(state_o), 32'(3'd2));
        tick(4);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("g_stable_late", 32'(state_o), 32'(3'd2));
        tick(1);
        check_outs("g_glitch", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        tick(1);
        check("g_restable", 32'(state_o), 32'(3'd2));
        tick(7);
        check_outs("g_fresh_pre", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        tick(1);
        check_outs("g_run", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

        // Three lock losses in RUN, each followed by a 4-cycle PLL reset.
        for (int i = 1; i <= 3; i++) begin
            pll_locked = 1'b0;
            tick(2);
            check("loss_ready_hold", 32'(ready), 32'(1'b1));
            tick(1);
            check_outs("loss", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'(i));
            pll_locked = 1'b1;
            tick(3);
            check("loss_pulse_end", 32'(pll_rst), 32'(1'b1));
            tick(1);
            check("loss_pulse_off", 32'(pll_rst), 32'(1'b0));
            tick(9);
            check("loss_rerun", 32'(ready), 32'(1'b1));
        end

        // Relock request coinciding with lock loss counts as a loss.
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check_outs("relock_and_loss", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd4);
        pll_locked = 1'b1;
        tick(4);
        check("rl_wait", 32'(state_o), 32'(3'd1));
        tick(9);
        check("rl_run", 32'(state_o), 32'(3'd3));

        // 300 further losses: counter must saturate at 255.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(13);
        end
        check_outs("loss_sat", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd255);

        // Reset in the middle of STABLE.
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("sat_relock_loss", 32'(loss_cnt), 32'(8'd255));
        tick(5);
        check("mid_stable", 32'(state_o), 32'(3'd2));
        tick(3);
        rst        = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        check_outs("rst_stable", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        rst = 1'b0;

        // Reset in the middle of FAULT.
        wait_state(3'd4, 200, "reach_fault");
        tick(3);
        check_outs("in_fault", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0);
        rst = 1'b1;
        tick(1);
        check_outs("rst_fault", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst", 32'(pll_rst), 32'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
